// File: rtl/dff_bank_arb_pkg.sv
// Shared types and helpers for the DFF bank write arbiter.
package dff_bank_arb_pkg;

  // Transaction FSM; encoding 2'd3 is unused and recovers to StIdle.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StAck   = 2'd2
  } state_e;

  // Widest one-hot vector the helper can produce; callers truncate to their own width.
  localparam int unsigned OneHotMax = 64;

  // Index to one-hot; indices beyond OneHotMax yield all zeros.
  function automatic logic [OneHotMax-1:0] idx_to_onehot(input int unsigned idx);
    logic [OneHotMax-1:0] oh;
    oh = '0;
    if (idx < OneHotMax) begin
      oh = {{(OneHotMax-1){1'b0}}, 1'b1} << idx;
    end
    return oh;
  endfunction

endpackage

// File: rtl/dff_bank_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [IdxW-1:0]    winner_o,
  output logic               any_o
);

  int unsigned idx;
  logic        found;

  // Scan NUM_REQ positions starting at the pointer; the first hit wins.
  always_comb begin
    winner_o = '0;
    any_o    = |req_i;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (32'(ptr_i) + off) % NUM_REQ;
      if (!found && req_i[idx]) begin
        winner_o = IdxW'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_bank_write_arbiter.sv
// Round-robin arbiter for the single write port of an enable-gated DFF register bank.
// One transaction is IDLE -> WRITE (one Enable pulse) -> ACK (Ack/Error pulse) -> IDLE.
module dff_bank_write_arbiter
  import dff_bank_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_REQ-1:0]               req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    data_i,
  output logic [NUM_REQ-1:0]               grant_o,
  output logic [NUM_REQ-1:0]               ack_o,
  output logic                             error_o,
  output logic [NUM_REGS-1:0]              enable_o,
  output logic [DATA_WIDTH-1:0]            d_o,
  output logic                             busy_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  state_e                  state_q;
  logic [IdxW-1:0]         ptr_q;
  logic [IdxW-1:0]         win_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [NUM_REQ-1:0]      grant_q;
  logic [NUM_REQ-1:0]      ack_q;
  logic                    error_q;
  logic [NUM_REGS-1:0]     enable_q;
  logic [DATA_WIDTH-1:0]   d_q;

  logic [IdxW-1:0]         arb_winner;
  logic                    arb_any;
  logic [ADDR_WIDTH-1:0]   addr_sel;
  logic [DATA_WIDTH-1:0]   data_sel;
  logic [NUM_REGS-1:0]     enable_dec;
  logic [NUM_REQ-1:0]      grant_dec;
  logic [NUM_REQ-1:0]      ack_dec;
  logic                    addr_q_in_range;
  logic [IdxW-1:0]         ptr_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .winner_o (arb_winner),
    .any_o    (arb_any)
  );

  // Select the winner's address/data and pre-decode the registered outputs for the IDLE edge.
  always_comb begin
    addr_sel  = addr_i[32'(arb_winner)*ADDR_WIDTH +: ADDR_WIDTH];
    data_sel  = data_i[32'(arb_winner)*DATA_WIDTH +: DATA_WIDTH];
    grant_dec = NUM_REQ'(idx_to_onehot(32'(arb_winner)));
    // Out-of-range addresses must never touch the bank.
    if (32'(addr_sel) < NUM_REGS) begin
      enable_dec = NUM_REGS'(idx_to_onehot(32'(addr_sel)));
    end else begin
      enable_dec = '0;
    end
  end

  // Values derived from the latched transaction, used in WRITE and ACK.
  always_comb begin
    ack_dec         = NUM_REQ'(idx_to_onehot(32'(win_q)));
    addr_q_in_range = (32'(addr_q) < NUM_REGS);
    ptr_next        = (32'(win_q) == NUM_REQ - 1) ? '0 : win_q + 1'b1;
  end

  // Transaction FSM with registered outputs; synchronous reset aborts any write in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      win_q    <= '0;
      addr_q   <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      error_q  <= 1'b0;
      enable_q <= '0;
      d_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          ack_q    <= '0;
          error_q  <= 1'b0;
          enable_q <= '0;
          grant_q  <= '0;
          if (arb_any) begin
            win_q    <= arb_winner;
            addr_q   <= addr_sel;
            d_q      <= data_sel;
            grant_q  <= grant_dec;
            enable_q <= enable_dec;
            state_q  <= StWrite;
          end
        end
        StWrite: begin
          // Grant and D hold; the Enable pulse ends and the owner is acknowledged.
          enable_q <= '0;
          ack_q    <= ack_dec;
          error_q  <= !addr_q_in_range;
          state_q  <= StAck;
        end
        StAck: begin
          ack_q   <= '0;
          error_q <= 1'b0;
          grant_q <= '0;
          ptr_q   <= ptr_next;
          state_q <= StIdle;
        end
        default: begin
          ack_q    <= '0;
          error_q  <= 1'b0;
          grant_q  <= '0;
          enable_q <= '0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  assign grant_o  = grant_q;
  assign ack_o    = ack_q;
  assign error_o  = error_q;
  assign enable_o = enable_q;
  assign d_o      = d_q;
  assign busy_o   = (state_q != StIdle);

endmodule

// File: tb/tb_dff_bank_write_arbiter.sv
// Scoreboard bench: stimulus pushes expected transactions, a negedge monitor checks each Ack.
module tb_dff_bank_write_arbiter;

  localparam int unsigned NReq  = 4;
  localparam int unsigned NRegs = 6;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 3;

  typedef struct {
    logic [NReq-1:0]  grant;
    logic [NRegs-1:0] en;
    logic [DW-1:0]    d;
    logic             err;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic [NReq-1:0]      req;
  logic [NReq*AW-1:0]   addr;
  logic [NReq*DW-1:0]   data;
  logic [NReq-1:0]      grant_o;
  logic [NReq-1:0]      ack_o;
  logic                 error_o;
  logic [NRegs-1:0]     enable_o;
  logic [DW-1:0]        d_o;
  logic                 busy_o;

  exp_t                 exp_q[$];
  logic [DW-1:0]        bank [NRegs];
  int                   tests = 0;
  int                   fails = 0;

  logic [NReq-1:0]      rec_grant;
  logic [NRegs-1:0]     rec_en;
  logic [DW-1:0]        rec_d;
  logic                 prev_en_on;

  dff_bank_write_arbiter #(
    .NUM_REQ    (NReq),
    .NUM_REGS   (NRegs),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (req),
    .addr_i   (addr),
    .data_i   (data),
    .grant_o  (grant_o),
    .ack_o    (ack_o),
    .error_o  (error_o),
    .enable_o (enable_o),
    .d_o      (d_o),
    .busy_o   (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the DFF bank being written.
  always @(posedge clk) begin
    for (int i = 0; i < NRegs; i++) begin
      if (enable_o[i]) bank[i] <= d_o;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: record the WRITE cycle, compare the whole transaction when Ack appears.
  initial prev_en_on = 1'b0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (enable_o != '0) begin
        check("enable_onehot", 32'($countones(enable_o)), 32'd1);
        check("enable_one_cycle", 32'(prev_en_on), 32'd0);
      end
      prev_en_on = (enable_o != '0);
      if (ack_o != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'(ack_o), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("grant_write", 32'(rec_grant), 32'(e.grant));
          check("enable_write", 32'(rec_en), 32'(e.en));
          check("d_write", 32'(rec_d), 32'(e.d));
          check("grant_ack", 32'(grant_o), 32'(e.grant));
          check("ack", 32'(ack_o), 32'(e.grant));
          check("error", 32'(error_o), 32'(e.err));
          check("enable_in_ack", 32'(enable_o), 32'd0);
        end
      end else if (grant_o != '0) begin
        rec_grant = grant_o;
        rec_en    = enable_o;
        rec_d     = d_o;
      end
    end else begin
      prev_en_on = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr[i*AW +: AW] = a;
    data[i*DW +: DW] = d;
  endtask

  task automatic push(input logic [NReq-1:0] g, input logic [NRegs-1:0] en,
                      input logic [DW-1:0] d, input logic err);
    exp_t e;
    e.grant = g;
    e.en    = en;
    e.d     = d;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(input int i);
    bit seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      tick();
      if (ack_o[i]) seen = 1'b1;
    end
    if (!seen) begin
      fails++;
      tests++;
      $display("FAIL ack_timeout: requester %0d got no Ack within 12 cycles", i);
    end
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int k = 0; k < 12 && !idle; k++) begin
      tick();
      if (!busy_o) idle = 1'b1;
    end
    if (!idle) begin
      fails++;
      tests++;
      $display("FAIL idle_timeout: Busy still 1 after 12 cycles");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    addr  = '0;
    data  = '0;
    set_port(0, 3'd1, 8'h11);
    set_port(1, 3'd3, 8'h22);
    set_port(2, 3'd4, 8'h33);
    set_port(3, 3'd5, 8'h44);

    // Reset held for two edges with every requester active.
    tick();
    tick();
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_error", 32'(error_o), 32'd0);
    check("rst_enable", 32'(enable_o), 32'd0);
    check("rst_d", 32'(d_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);

    // First grant after release goes to requester 0; pointer becomes 1.
    push(4'b0001, 6'b000010, 8'h11, 1'b0);
    rst_n = 1'b1;
    wait_ack(0);
    req = '0;
    wait_idle();

    // Single write from requester 2 to register 5; pointer becomes 3.
    set_port(2, 3'd5, 8'hA5);
    req = 4'b0100;
    push(4'b0100, 6'b100000, 8'hA5, 1'b0);
    wait_ack(2);
    req = '0;
    wait_idle();
    check("bank5", 32'(bank[5]), 32'h0000_00A5);

    // Wrap: pointer 3 with Req=1001 -> 3 then 0; pointer returns to 1.
    set_port(3, 3'd4, 8'h3C);
    set_port(0, 3'd0, 8'hC0);
    req = 4'b1001;
    push(4'b1000, 6'b010000, 8'h3C, 1'b0);
    push(4'b0001, 6'b000001, 8'hC0, 1'b0);
    wait_ack(3);
    req[3] = 1'b0;
    wait_ack(0);
    req = '0;
    wait_idle();

    // Pointer probe: only pointer 1 picks requester 1 out of 1011.
    set_port(0, 3'd1, 8'h10);
    set_port(1, 3'd3, 8'h77);
    set_port(3, 3'd2, 8'h33);
    req = 4'b1011;
    push(4'b0010, 6'b001000, 8'h77, 1'b0);
    wait_ack(1);
    req = '0;
    wait_idle();

    // Out-of-range address: no Enable, Error with Ack.
    set_port(1, 3'd7, 8'h99);
    req = 4'b0010;
    push(4'b0010, 6'b000000, 8'h99, 1'b1);
    wait_ack(1);
    req = '0;
    wait_idle();

    // Req dropped and inputs changed during WRITE: latched write still completes.
    set_port(2, 3'd2, 8'h5A);
    req = 4'b0100;
    push(4'b0100, 6'b000100, 8'h5A, 1'b0);
    tick();
    req = '0;
    set_port(2, 3'd0, 8'hFF);
    wait_ack(2);
    wait_idle();
    check("bank2_latched", 32'(bank[2]), 32'h0000_005A);

    // Reset during WRITE: no Ack ever, outputs cleared, pointer back to 0.
    set_port(3, 3'd1, 8'hEE);
    req = 4'b1000;
    tick();
    check("mid_busy_write", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid_enable", 32'(enable_o), 32'd0);
    check("mid_grant", 32'(grant_o), 32'd0);
    check("mid_ack", 32'(ack_o), 32'd0);
    check("mid_busy", 32'(busy_o), 32'd0);
    rst_n = 1'b1;
    req = '0;
    tick();
    tick();
    tick();

    // Fairness with all requesting: order 0,1,2,3,0.
    set_port(0, 3'd1, 8'hF0);
    set_port(1, 3'd2, 8'hF1);
    set_port(2, 3'd3, 8'hF2);
    set_port(3, 3'd5, 8'hF3);
    push(4'b0001, 6'b000010, 8'hF0, 1'b0);
    push(4'b0010, 6'b000100, 8'hF1, 1'b0);
    push(4'b0100, 6'b001000, 8'hF2, 1'b0);
    push(4'b1000, 6'b100000, 8'hF3, 1'b0);
    push(4'b0001, 6'b000010, 8'hF0, 1'b0);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(k % 4);
      if (k == 4) begin
        req = '0;
      end else begin
        tick();
        req[k % 4] = 1'b0;
        tick();
        req[k % 4] = 1'b1;
      end
    end
    wait_idle();
    tick();
    tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
